// File: rtl/wc_pkg.sv
// Shared definitions for the WC_2_4 Winograd datapath: word and tile widths,
// tile-loader FSM encoding and the buffered tile record.
package wc_pkg;
    localparam int W      = 10;
    localparam int TG_W   = 3 * W;
    localparam int TD_W   = 4 * W;
    localparam int TILE_W = TG_W + TD_W;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        FILT = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef struct packed {
        logic [TG_W-1:0] g;
        logic [TD_W-1:0] d;
    } tile_t;
endpackage

// File: rtl/wc_tile_loader_if.sv
// Pad-side word stream and core-side tile handshake of the tile loader.
interface wc_tile_loader_if;
    import wc_pkg::*;

    logic            in_valid;
    logic [W-1:0]    in_d;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [TG_W-1:0] out_g;
    logic [TD_W-1:0] out_d;
    logic            busy;

    modport slave (
        input  in_valid, in_d, out_ready,
        output in_ready, out_valid, out_g, out_d, busy
    );

    modport master (
        output in_valid, in_d, out_ready,
        input  in_ready, out_valid, out_g, out_d, busy
    );
endinterface

// File: rtl/wc_tile_fifo.sv
// DEPTH-entry tile FIFO with a registered head; a push into an empty (or
// draining-to-empty) buffer is forwarded so the tile appears the next cycle.
module wc_tile_fifo
    import wc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  tile_t push_data,
    input  logic  pop,
    output tile_t head,
    output logic  full,
    output logic  empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];

    tile_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   occ_reg;
    tile_t         head_reg;
    tile_t         head_next;
    logic          do_push;
    logic          do_pop;

    assign full    = (occ_reg == FULL_OCC);
    assign empty   = (occ_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = head_reg;

    // Head register tracks whichever entry will sit at the read pointer after
    // this cycle, bypassing the write when that entry is being filled now.
    always_comb begin
        rd_ptr_next = do_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        head_next   = mem[rd_ptr_next];
        if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            head_reg   <= head_next;
            case ({do_push, do_pop})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/wc_tile_loader.sv
// Frames the pad word stream into {g, d} tiles for the WC_2_4 core and buffers
// finished tiles so framing can continue while the core stalls.
module wc_tile_loader
    import wc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    wc_tile_loader_if.slave  bus
);
    state_t          state_reg;
    logic [1:0]      cnt_reg;
    logic [2:0][W-1:0] g_reg;
    logic [2:0][W-1:0] d_reg;
    logic [2:0]      g_we;
    logic [2:0]      d_we;
    logic            last_word;
    logic            ready;
    logic            accept;
    logic            push;
    logic            full;
    logic            empty;
    tile_t           push_tile;
    tile_t           head;

    // Only the tile-completing word can be refused; everything else is staged.
    assign last_word = (state_reg == DATA) && (cnt_reg == 2'd3);
    assign ready     = !(last_word && full);
    assign accept    = bus.in_valid && ready;
    assign push      = accept && last_word;

    assign push_tile.g = g_reg;
    assign push_tile.d = {bus.in_d, d_reg};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            assign g_we[gi] = accept && (state_reg == FILT) && (cnt_reg == 2'(gi));
            assign d_we[gi] = accept && (state_reg == DATA) && (cnt_reg == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            g_reg <= '0;
            d_reg <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (g_we[i]) g_reg[i] <= bus.in_d;
                if (d_we[i]) d_reg[i] <= bus.in_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= HDR;
            cnt_reg   <= '0;
        end else if (accept) begin
            case (state_reg)
                HDR: begin
                    state_reg <= bus.in_d[W-1] ? FILT : DATA;
                    cnt_reg   <= '0;
                end
                FILT: begin
                    if (cnt_reg == 2'd2) begin
                        state_reg <= DATA;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == 2'd3) begin
                        state_reg <= HDR;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= HDR;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    wc_tile_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_tile),
        .pop       (bus.out_ready),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign bus.in_ready  = ready;
    assign bus.out_valid = !empty;
    assign bus.out_g     = head.g;
    assign bus.out_d     = head.d;
    assign bus.busy      = (state_reg != HDR);
endmodule
